// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - two-requester writeback handshake bundle for rf_wb_arbiter
interface rf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int PPP_WIDTH  = 3
);
    // Requester A: ALU/EX writeback
    logic                  a_valid;
    logic                  a_ready;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [0:DATA_WIDTH-1] a_data;
    logic [PPP_WIDTH-1:0]  a_ppp;

    // Requester B: load / NIC-response writeback
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [0:DATA_WIDTH-1] b_data;
    logic [PPP_WIDTH-1:0]  b_ppp;

    modport master (
        output a_valid, a_addr, a_data, a_ppp,
        output b_valid, b_addr, b_data, b_ppp,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data, a_ppp,
        input  b_valid, b_addr, b_data, b_ppp,
        output a_ready, b_ready
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - B-priority writeback arbiter for the REGFILE32x64 write port; RF_WB_STARVE_GUARD_EN adds an A starvation guard
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int PPP_WIDTH  = 3,
    parameter int MAX_WAIT   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    rf_wb_arbiter_if.slave        req,
    output logic                  wrEn,
    output logic [ADDR_WIDTH-1:0] wrAddr,
    output logic [0:DATA_WIDTH-1] dataIn,
    output logic [PPP_WIDTH-1:0]  ppp,
    output logic [CNT_WIDTH-1:0]  conflict_cnt,
    output logic                  grant_b_last
);

    // The wait counter is 3 bits wide, so the forced-grant threshold must fit in it.
    if (MAX_WAIT < 1 || MAX_WAIT > 7) begin : g_bad_max_wait
        $error("rf_wb_arbiter: MAX_WAIT must be in 1..7");
    end

    logic a_take;
    logic b_take;
    logic force_a;

`ifdef RF_WB_STARVE_GUARD_EN
    logic [2:0] wait_cnt;

    assign force_a = req.a_valid && (wait_cnt == 3'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!req.a_valid || a_take) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end
`else
    assign force_a = 1'b0;
`endif

    // The regfile never stalls, so exactly one requester is ready whenever any is valid.
    always_comb begin
        a_take = 1'b0;
        b_take = 1'b0;
        if (!reset) begin
            if (force_a) begin
                a_take = 1'b1;
            end else if (req.b_valid) begin
                b_take = 1'b1;
            end else if (req.a_valid) begin
                a_take = 1'b1;
            end
        end
    end

    assign req.a_ready = a_take;
    assign req.b_ready = b_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrEn         <= 1'b0;
            wrAddr       <= '0;
            dataIn       <= '0;
            ppp          <= '0;
            grant_b_last <= 1'b0;
        end else begin
            wrEn <= a_take || b_take;
            if (b_take) begin
                wrAddr       <= req.b_addr;
                dataIn       <= req.b_data;
                ppp          <= req.b_ppp;
                grant_b_last <= 1'b1;
            end else if (a_take) begin
                wrAddr       <= req.a_addr;
                dataIn       <= req.a_data;
                ppp          <= req.a_ppp;
                grant_b_last <= 1'b0;
            end
        end
    end

    // Contention statistic saturates rather than wrapping so long runs stay meaningful.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (req.a_valid && req.b_valid && (conflict_cnt != {CNT_WIDTH{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed table and sequence bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int PW = 3;
    localparam int MW = 4;
    localparam int CW = 4;
`ifdef RF_WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PPP_WIDTH(PW)) bus ();

    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [0:DW-1] dataIn;
    logic [PW-1:0] ppp;
    logic [CW-1:0] conflict_cnt;
    logic          grant_b_last;

    rf_wb_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PPP_WIDTH(PW), .MAX_WAIT(MW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .req(bus),
        .wrEn(wrEn), .wrAddr(wrAddr), .dataIn(dataIn), .ppp(ppp),
        .conflict_cnt(conflict_cnt), .grant_b_last(grant_b_last)
    );

    // Register file model: writes on the edge after wrEn is presented.
    logic [63:0] rf [0:31];
    always @(posedge clk) if (wrEn) rf[wrAddr] <= dataIn;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [4:0] ad, input logic [63:0] d, input logic [2:0] p);
        bus.a_valid = v; bus.a_addr = ad; bus.a_data = d; bus.a_ppp = p;
    endtask

    task automatic set_b(input logic v, input logic [4:0] ad, input logic [63:0] d, input logic [2:0] p);
        bus.b_valid = v; bus.b_addr = ad; bus.b_data = d; bus.b_ppp = p;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        av, bv;
        logic [4:0]  aa, ba;
        logic [63:0] ad, bd;
        logic [2:0]  ap, bp;
        logic        ea, eb, ew;
        logic [4:0]  eaddr;
        logic [63:0] edata;
        logic [2:0]  eppp;
        logic        egb;
    } vec_t;

    vec_t vt [7];

    initial begin
        vt[0] = '{1'b1, 1'b0, 5'd5, 5'd0, 64'hffff_ffff_ffff_ffff, 64'h0, 3'd0, 3'd0,
                  1'b1, 1'b0, 1'b1, 5'd5, 64'hffff_ffff_ffff_ffff, 3'd0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 5'd0, 5'd31, 64'h0, 64'h0123_4567_89ab_cdef, 3'd0, 3'd7,
                  1'b0, 1'b1, 1'b1, 5'd31, 64'h0123_4567_89ab_cdef, 3'd7, 1'b1};
        vt[2] = '{1'b0, 1'b0, 5'd0, 5'd0, 64'h0, 64'h0, 3'd0, 3'd0,
                  1'b0, 1'b0, 1'b0, 5'd31, 64'h0123_4567_89ab_cdef, 3'd7, 1'b1};
        vt[3] = '{1'b1, 1'b0, 5'd0, 5'd0, 64'h0, 64'h0, 3'd5, 3'd0,
                  1'b1, 1'b0, 1'b1, 5'd0, 64'h0, 3'd5, 1'b0};
        vt[4] = '{1'b0, 1'b1, 5'd0, 5'd0, 64'h0, 64'hdead_beef_cafe_f00d, 3'd0, 3'd6,
                  1'b0, 1'b1, 1'b1, 5'd0, 64'hdead_beef_cafe_f00d, 3'd6, 1'b1};
        vt[5] = '{1'b0, 1'b0, 5'd0, 5'd0, 64'h0, 64'h0, 3'd0, 3'd0,
                  1'b0, 1'b0, 1'b0, 5'd0, 64'hdead_beef_cafe_f00d, 3'd6, 1'b1};
        vt[6] = '{1'b1, 1'b0, 5'd17, 5'd0, 64'ha5a5_a5a5_5a5a_5a5a, 64'h0, 3'd3, 3'd0,
                  1'b1, 1'b0, 1'b1, 5'd17, 64'ha5a5_a5a5_5a5a_5a5a, 3'd3, 1'b0};

        // Reset held two cycles with both requesters valid.
        reset = 1'b1;
        set_a(1'b1, 5'd1, 64'h11, 3'd1);
        set_b(1'b1, 5'd2, 64'h22, 3'd2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_a_ready", bus.a_ready, 0);
            chk("rst_b_ready", bus.b_ready, 0);
            chk("rst_wren", wrEn, 0);
            chk("rst_cnt", conflict_cnt, 0);
            chk("rst_gbl", grant_b_last, 0);
            tick();
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_wren", wrEn, 0);
        chk("post_rst_cnt", conflict_cnt, 0);
        chk("post_rst_b_ready", bus.b_ready, 1);
        chk("post_rst_wraddr", wrAddr, 0);
        tick();
        // B was accepted on that edge; reset now must discard its pending write.
        chk("pre_rst_wren", wrEn, 1);
        do_reset();
        chk("rst_discard_wren", wrEn, 0);
        chk("rst_discard_dataIn", dataIn, 0);

        // Table-driven single-requester vectors.
        for (int i = 0; i < 7; i++) begin
            set_a(vt[i].av, vt[i].aa, vt[i].ad, vt[i].ap);
            set_b(vt[i].bv, vt[i].ba, vt[i].bd, vt[i].bp);
            @(negedge clk);
            chk($sformatf("v%0d_a_ready", i), bus.a_ready, vt[i].ea);
            chk($sformatf("v%0d_b_ready", i), bus.b_ready, vt[i].eb);
            tick();
            chk($sformatf("v%0d_wren", i), wrEn, vt[i].ew);
            chk($sformatf("v%0d_wraddr", i), wrAddr, vt[i].eaddr);
            chk($sformatf("v%0d_dataIn", i), dataIn, vt[i].edata);
            chk($sformatf("v%0d_ppp", i), ppp, vt[i].eppp);
            chk($sformatf("v%0d_gbl", i), grant_b_last, vt[i].egb);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();
        chk("tbl_rf5", rf[5], 64'hffff_ffff_ffff_ffff);
        chk("tbl_rf0", rf[0], 64'hdead_beef_cafe_f00d);
        chk("tbl_rf17", rf[17], 64'ha5a5_a5a5_5a5a_5a5a);
        chk("tbl_cnt", conflict_cnt, 0);

        // Collision on the same destination: B first, A second, A's value final.
        do_reset();
        set_a(1'b1, 5'd3, 64'h1111_1111_1111_1111, 3'd1);
        set_b(1'b1, 5'd3, 64'h2222_2222_2222_2222, 3'd2);
        @(negedge clk);
        chk("col_b_ready", bus.b_ready, 1);
        chk("col_a_ready0", bus.a_ready, 0);
        tick();
        bus.b_valid = 1'b0;
        chk("col_wren0", wrEn, 1);
        chk("col_data0", dataIn, 64'h2222_2222_2222_2222);
        chk("col_gbl0", grant_b_last, 1);
        @(negedge clk);
        chk("col_a_ready1", bus.a_ready, 1);
        tick();
        bus.a_valid = 1'b0;
        chk("col_wren1", wrEn, 1);
        chk("col_addr1", wrAddr, 3);
        chk("col_data1", dataIn, 64'h1111_1111_1111_1111);
        chk("col_ppp1", ppp, 1);
        chk("col_gbl1", grant_b_last, 0);
        tick();
        chk("col_wren2", wrEn, 0);
        chk("col_hold_data", dataIn, 64'h1111_1111_1111_1111);
        chk("col_rf3", rf[3], 64'h1111_1111_1111_1111);
        chk("col_cnt", conflict_cnt, 1);

        // Starvation: B valid for 10 cycles against a waiting A.
        do_reset();
        set_a(1'b1, 5'd9, 64'h9999_0000_9999_0000, 3'd4);
        for (int i = 0; i < 10; i++) begin
            logic exp_a;
            exp_a = GUARD && (i == MW || i == 2 * MW + 1);
            set_b(1'b1, 5'd10, 64'(i), 3'd0);
            @(negedge clk);
            chk($sformatf("stv%0d_a_ready", i), bus.a_ready, exp_a);
            chk($sformatf("stv%0d_b_ready", i), bus.b_ready, !exp_a);
            tick();
            chk($sformatf("stv%0d_gbl", i), grant_b_last, !exp_a);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        chk("stv_cnt", conflict_cnt, 10);

        // Saturation of the 4-bit contention counter.
        do_reset();
        set_a(1'b1, 5'd4, 64'h4, 3'd0);
        set_b(1'b1, 5'd8, 64'h8, 3'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("sat%0d_cnt", i), conflict_cnt, (i > 15) ? 15 : i);
            tick();
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        chk("sat_final_cnt", conflict_cnt, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
